// File: rtl/fp8_mul_arbiter_if.sv
// Bus bundle for fp8_mul_arbiter: two operand handshakes, the multiplier issue/product
// path, and two response FIFO heads.
// slave  : arbiter view (accepts requests, drives the multiplier, presents responses).
// master : environment view (offers requests, computes products, consumes responses).
interface fp8_mul_arbiter_if;
  logic       req0_valid;
  logic       req0_ready;
  logic [7:0] req0_a;
  logic [7:0] req0_b;
  logic       req1_valid;
  logic       req1_ready;
  logic [7:0] req1_a;
  logic [7:0] req1_b;
  logic       mul_valid;
  logic [7:0] mul_a;
  logic [7:0] mul_b;
  logic [7:0] mul_p;
  logic       rsp0_valid;
  logic       rsp0_ready;
  logic [7:0] rsp0_p;
  logic       rsp1_valid;
  logic       rsp1_ready;
  logic [7:0] rsp1_p;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output req0_ready, req1_ready,
    output mul_valid, mul_a, mul_b,
    input  mul_p,
    output rsp0_valid, rsp0_p, rsp1_valid, rsp1_p,
    input  rsp0_ready, rsp1_ready
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  req0_ready, req1_ready,
    input  mul_valid, mul_a, mul_b,
    output mul_p,
    input  rsp0_valid, rsp0_p, rsp1_valid, rsp1_p,
    output rsp0_ready, rsp1_ready
  );
endinterface

// File: rtl/fp8_mul_arbiter.sv
// fp8_mul_arbiter: round-robin sharing of one fixed-latency FP8 multiplier between two
// requesters. Results are routed back by a tag pipeline into per-requester response
// FIFOs; issue is credit-gated so a result always has a FIFO slot waiting for it.
// Ports:
//   clk  clock
//   rst  synchronous active-high reset
//   bus  fp8_mul_arbiter_if.slave: req{0,1} operand handshakes, mul_* multiplier
//        issue/product, rsp{0,1} response FIFO heads (valid/ready)
module fp8_mul_arbiter #(
  parameter int unsigned MUL_LAT    = 2,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  fp8_mul_arbiter_if.slave bus
);
  localparam int unsigned DATA_W = 8;
  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W  = CNT_W + 1;

  typedef enum logic {PRI_0 = 1'b0, PRI_1 = 1'b1} pri_e;

  pri_e                   pri_q;
  pri_e                   pri_d;
  logic [1:0]             req_valid;
  logic [1:0]             rsp_ready;
  logic [1:0]             credit;
  logic [1:0]             elig;
  logic [1:0]             grant_c;
  logic [1:0]             push;
  logic [1:0]             pop;
  logic [1:0]             rsp_valid;
  logic [1:0][DATA_W-1:0] rsp_p;

  logic                   mul_valid_q;
  logic [DATA_W-1:0]      mul_a_q;
  logic [DATA_W-1:0]      mul_b_q;
  logic                   mul_id_q;
  logic [MUL_LAT-1:0]     tag_v_q;
  logic [MUL_LAT-1:0]     tag_id_q;
  logic                   wb_v;
  logic                   wb_id;

  assign req_valid = {bus.req1_valid, bus.req0_valid};
  assign rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
  assign elig      = req_valid & credit & {2{~rst}};

  // Priority pointer register
  always_ff @(posedge clk) begin
    if (rst) pri_q <= PRI_0;
    else     pri_q <= pri_d;
  end

  // Grant selection and pointer update: the loser of a grant gets priority next time
  always_comb begin
    grant_c = '0;
    pri_d   = pri_q;
    if (elig == 2'b11) grant_c = (pri_q == PRI_0) ? 2'b01 : 2'b10;
    else               grant_c = elig;
    if (grant_c[0])      pri_d = PRI_1;
    else if (grant_c[1]) pri_d = PRI_0;
  end

  // Issue register plus tag pipeline; the tag stage fed by mul_valid_q lines up
  // with mul_p after MUL_LAT further cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      mul_id_q    <= 1'b0;
      tag_v_q     <= '0;
      tag_id_q    <= '0;
    end else begin
      mul_valid_q <= |grant_c;
      if (|grant_c) begin
        mul_a_q  <= grant_c[1] ? bus.req1_a : bus.req0_a;
        mul_b_q  <= grant_c[1] ? bus.req1_b : bus.req0_b;
        mul_id_q <= grant_c[1];
      end
      tag_v_q  <= (tag_v_q << 1) | MUL_LAT'(mul_valid_q);
      tag_id_q <= (tag_id_q << 1) | MUL_LAT'(mul_id_q);
    end
  end

  assign wb_v  = tag_v_q[MUL_LAT-1];
  assign wb_id = tag_id_q[MUL_LAT-1];

  for (genvar g = 0; g < 2; g++) begin : g_rq
    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  inflight_q;

    assign credit[g]    = (SUM_W'(inflight_q) + SUM_W'(count_q)) < SUM_W'(FIFO_DEPTH);
    assign push[g]      = wb_v && (wb_id == 1'(g));
    assign rsp_valid[g] = (count_q != '0);
    assign pop[g]       = rsp_valid[g] && rsp_ready[g];
    assign rsp_p[g]     = rsp_valid[g] ? mem[rd_ptr_q] : '0;

    // Payload storage; contents are only observed behind rsp_valid, so no reset
    always_ff @(posedge clk) begin
      if (push[g]) mem[wr_ptr_q] <= bus.mul_p;
    end

    // Pointers (wrap naturally at the power-of-two depth), occupancy and in-flight count
    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr_q   <= '0;
        rd_ptr_q   <= '0;
        count_q    <= '0;
        inflight_q <= '0;
      end else begin
        if (push[g]) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop[g])  rd_ptr_q <= rd_ptr_q + 1'b1;
        case ({push[g], pop[g]})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: ;
        endcase
        case ({grant_c[g], push[g]})
          2'b10:   inflight_q <= inflight_q + 1'b1;
          2'b01:   inflight_q <= inflight_q - 1'b1;
          default: ;
        endcase
      end
    end
  end

  assign bus.req0_ready = grant_c[0];
  assign bus.req1_ready = grant_c[1];
  assign bus.mul_valid  = mul_valid_q;
  assign bus.mul_a      = mul_a_q;
  assign bus.mul_b      = mul_b_q;
  assign bus.rsp0_valid = rsp_valid[0];
  assign bus.rsp0_p     = rsp_p[0];
  assign bus.rsp1_valid = rsp_valid[1];
  assign bus.rsp1_p     = rsp_p[1];
endmodule

// File: tb/tb_fp8_mul_arbiter.sv
// Testbench for fp8_mul_arbiter: E4M3 multiplier model with garbage on idle cycles,
// a queue-based reference of accepted-but-unconsumed operations per requester, and
// scenario tasks with their own targeted comparisons.
module tb_fp8_mul_arbiter;
  localparam int MUL_LAT    = 2;
  localparam int FIFO_DEPTH = 4;

  typedef struct {
    logic [7:0] v;
    int         rdy;
  } ent_t;

  logic clk;
  logic rst;
  int   n_err;
  int   n_chk;

  fp8_mul_arbiter_if bus();

  fp8_mul_arbiter #(.MUL_LAT(MUL_LAT), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // E4M3 product: normals only, subnormal inputs/results flush to zero, truncating,
  // saturating to the largest finite value.
  function automatic logic [7:0] fmul(input logic [7:0] a, input logic [7:0] b);
    int   ea, eb, e, m;
    logic s;
    s  = a[7] ^ b[7];
    ea = int'(a[6:3]);
    eb = int'(b[6:3]);
    if (ea == 0 || eb == 0) return {s, 7'h00};
    m = (8 + int'(a[2:0])) * (8 + int'(b[2:0]));
    e = ea + eb - 7;
    if (m >= 128) begin
      m = m / 16;
      e = e + 1;
    end else begin
      m = m / 8;
    end
    if (e >= 16 || (e == 15 && m >= 15)) return {s, 7'h7E};
    if (e <= 0) return {s, 7'h00};
    return {s, 4'(e), 3'(m - 8)};
  endfunction

  // Multiplier model: product appears MUL_LAT cycles after the mul_valid cycle
  logic [7:0] mp [MUL_LAT];
  always @(posedge clk) begin
    mp[0] <= bus.mul_valid ? fmul(bus.mul_a, bus.mul_b) : 8'($urandom);
    for (int k = 1; k < MUL_LAT; k++) mp[k] <= mp[k-1];
  end
  assign bus.mul_p = mp[MUL_LAT-1];

  // Reference: each accepted op waits in its requester's queue until consumed and
  // becomes visible 2+MUL_LAT cycles after acceptance.
  ent_t       q0[$];
  ent_t       q1[$];
  logic       m_known = 1'b0;
  logic       m_ptr, m_mv;
  logic [7:0] m_ma, m_mb;
  int         cyc = 0;
  logic       ev0, ev1, e0, e1, g0, g1;
  logic [7:0] ep0, ep1;

  always @(negedge clk) begin
    ev0 = (q0.size() > 0) && (q0[0].rdy <= cyc);
    ev1 = (q1.size() > 0) && (q1[0].rdy <= cyc);
    ep0 = ev0 ? q0[0].v : 8'h00;
    ep1 = ev1 ? q1[0].v : 8'h00;
    if (m_known) begin
      n_chk++;
      if ({bus.mul_valid, bus.mul_a, bus.mul_b} !== {m_mv, m_ma, m_mb}) begin
        n_err++;
        $display("FAIL mon_mul cyc=%0d: got v=%b a=%h b=%h want v=%b a=%h b=%h",
                 cyc, bus.mul_valid, bus.mul_a, bus.mul_b, m_mv, m_ma, m_mb);
      end
      n_chk++;
      if ({bus.rsp0_valid, bus.rsp0_p} !== {ev0, ep0}) begin
        n_err++;
        $display("FAIL mon_rsp0 cyc=%0d: got v=%b p=%h want v=%b p=%h",
                 cyc, bus.rsp0_valid, bus.rsp0_p, ev0, ep0);
      end
      n_chk++;
      if ({bus.rsp1_valid, bus.rsp1_p} !== {ev1, ep1}) begin
        n_err++;
        $display("FAIL mon_rsp1 cyc=%0d: got v=%b p=%h want v=%b p=%h",
                 cyc, bus.rsp1_valid, bus.rsp1_p, ev1, ep1);
      end
    end
    if (rst) begin
      n_chk++;
      if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin
        n_err++;
        $display("FAIL mon_ready_in_reset cyc=%0d: got %b%b want 00",
                 cyc, bus.req0_ready, bus.req1_ready);
      end
      q0.delete();
      q1.delete();
      m_ptr   = 1'b0;
      m_mv    = 1'b0;
      m_ma    = 8'h00;
      m_mb    = 8'h00;
      m_known = 1'b1;
    end else if (m_known) begin
      e0 = bus.req0_valid && (q0.size() < FIFO_DEPTH);
      e1 = bus.req1_valid && (q1.size() < FIFO_DEPTH);
      g0 = e0 && (!e1 || !m_ptr);
      g1 = e1 && (!e0 || m_ptr);
      n_chk++;
      if ({bus.req0_ready, bus.req1_ready} !== {g0, g1}) begin
        n_err++;
        $display("FAIL mon_grant cyc=%0d: got %b%b want %b%b",
                 cyc, bus.req0_ready, bus.req1_ready, g0, g1);
      end
      n_chk++;
      if ((bus.req0_ready && bus.req0_valid && q0.size() >= FIFO_DEPTH) ||
          (bus.req1_ready && bus.req1_valid && q1.size() >= FIFO_DEPTH)) begin
        n_err++;
        $display("FAIL mon_credit cyc=%0d: accept with outstanding %0d/%0d, limit %0d",
                 cyc, q0.size(), q1.size(), FIFO_DEPTH);
      end
      if (ev0 && bus.rsp0_ready) void'(q0.pop_front());
      if (ev1 && bus.rsp1_ready) void'(q1.pop_front());
      m_mv = g0 || g1;
      if (g0) begin
        q0.push_back('{v: fmul(bus.req0_a, bus.req0_b), rdy: cyc + 2 + MUL_LAT});
        m_ma  = bus.req0_a;
        m_mb  = bus.req0_b;
        m_ptr = 1'b1;
      end else if (g1) begin
        q1.push_back('{v: fmul(bus.req1_a, bus.req1_b), rdy: cyc + 2 + MUL_LAT});
        m_ma  = bus.req1_a;
        m_mb  = bus.req1_b;
        m_ptr = 1'b0;
      end
    end
    cyc++;
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
  endtask

  task automatic drain(input int n);
    idle_inputs();
    for (int k = 0; k < n; k++) next_cycle();
    @(negedge clk);
    n_chk++;
    if ({bus.rsp0_valid, bus.rsp1_valid} !== 2'b00) begin
      n_err++;
      $display("FAIL drain_empty: got %b%b want 00", bus.rsp0_valid, bus.rsp1_valid);
    end
    next_cycle();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 8'h38; bus.req0_b = 8'h38;
    bus.req1_valid = 1'b1; bus.req1_a = 8'h40; bus.req1_b = 8'h40;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_chk++;
      if ({bus.req0_ready, bus.req1_ready, bus.mul_valid, bus.rsp0_valid, bus.rsp1_valid} !== 5'b0) begin
        n_err++;
        $display("FAIL reset_hold: got rdy=%b%b mv=%b rv=%b%b want all 0", bus.req0_ready,
                 bus.req1_ready, bus.mul_valid, bus.rsp0_valid, bus.rsp1_valid);
      end
      next_cycle();
    end
    rst = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin
      n_err++;
      $display("FAIL reset_first_grant: got %b%b want 10", bus.req0_ready, bus.req1_ready);
    end
    next_cycle();
    idle_inputs();
  endtask

  task automatic test_single();
    bus.req0_valid = 1'b1; bus.req0_a = 8'h38; bus.req0_b = 8'h40;
    @(negedge clk);
    n_chk++;
    if (bus.req0_ready !== 1'b1) begin
      n_err++;
      $display("FAIL single_accept: got %b want 1", bus.req0_ready);
    end
    next_cycle();
    bus.req0_valid = 1'b0;
    @(negedge clk);
    n_chk++;
    if ({bus.mul_valid, bus.mul_a, bus.mul_b} !== {1'b1, 8'h38, 8'h40}) begin
      n_err++;
      $display("FAIL single_issue: got v=%b a=%h b=%h want v=1 a=38 b=40",
               bus.mul_valid, bus.mul_a, bus.mul_b);
    end
    for (int k = 2; k <= 4; k++) begin
      next_cycle();
      @(negedge clk);
      n_chk++;
      if ({bus.rsp0_valid, bus.rsp1_valid} !== {(k == 4), 1'b0} ||
          (k == 4 && bus.rsp0_p !== 8'h40)) begin
        n_err++;
        $display("FAIL single_rsp cycle %0d: got v0=%b v1=%b p0=%h want v0=%b v1=0 p0=40",
                 k, bus.rsp0_valid, bus.rsp1_valid, bus.rsp0_p, (k == 4));
      end
    end
    next_cycle();
  endtask

  task automatic test_contention();
    logic prev_r1;
    int   n1;
    prev_r1 = 1'b0;
    n1      = 0;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1; bus.req1_a = 8'h38; bus.req1_b = 8'h38;
    for (int k = 0; k < 18; k++) begin
      if (k == 8) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      bus.req0_a = 8'($urandom); bus.req0_b = 8'($urandom);
      @(negedge clk);
      if (k < 8) begin
        n_chk++;
        if ((bus.req0_ready ^ bus.req1_ready) !== 1'b1 || (k > 0 && bus.req0_ready !== prev_r1)) begin
          n_err++;
          $display("FAIL contention_alternate k=%0d: got %b%b want one-hot with r0=%b",
                   k, bus.req0_ready, bus.req1_ready, prev_r1);
        end
        prev_r1 = bus.req1_ready;
      end
      if (bus.rsp1_valid === 1'b1) begin
        n1++;
        n_chk++;
        if (bus.rsp1_p !== 8'h38) begin
          n_err++;
          $display("FAIL contention_rsp1_value: got %h want 38", bus.rsp1_p);
        end
      end
      next_cycle();
    end
    n_chk++;
    if (n1 != 4) begin
      n_err++;
      $display("FAIL contention_rsp1_count: got %0d want 4", n1);
    end
  endtask

  task automatic test_backpressure();
    int  acc0, acc1;
    logic seen;
    acc0 = 0;
    acc1 = 0;
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b1;
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    for (int k = 0; k < 16; k++) begin
      bus.req0_a = 8'($urandom); bus.req0_b = 8'($urandom);
      bus.req1_a = 8'($urandom); bus.req1_b = 8'($urandom);
      @(negedge clk);
      if (bus.req0_ready === 1'b1) acc0++;
      if (bus.req1_ready === 1'b1) acc1++;
      if (k >= 10) begin
        n_chk++;
        if (bus.req0_ready !== 1'b0) begin
          n_err++;
          $display("FAIL bp_req0_blocked k=%0d: got %b want 0", k, bus.req0_ready);
        end
      end
      next_cycle();
    end
    n_chk++;
    if (acc0 != FIFO_DEPTH || acc1 < 8) begin
      n_err++;
      $display("FAIL bp_accepts: got req0=%0d req1=%0d want req0=%0d req1>=8", acc0, acc1, FIFO_DEPTH);
    end
    bus.req1_valid = 1'b0;
    bus.rsp0_ready = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 12; k++) begin
      bus.req0_a = 8'($urandom); bus.req0_b = 8'($urandom);
      @(negedge clk);
      if (bus.req0_ready === 1'b1) seen = 1'b1;
      next_cycle();
    end
    n_chk++;
    if (seen !== 1'b1) begin
      n_err++;
      $display("FAIL bp_resume: req0_ready got %b within 12 cycles, want 1", seen);
    end
    drain(14);
  endtask

  task automatic test_full_push_pop();
    bus.rsp0_ready = 1'b0;
    bus.req0_valid = 1'b1;
    for (int k = 0; k < 9; k++) begin
      bus.req0_a = 8'($urandom); bus.req0_b = 8'($urandom);
      if (k == 4) bus.req0_valid = 1'b0;
      if (k == 6) bus.rsp0_ready = 1'b1;
      if (k == 7) begin
        bus.rsp0_ready = 1'b0;
        bus.req0_valid = 1'b1;
      end
      @(negedge clk);
      if (k < 4 || k >= 7) begin
        n_chk++;
        if (bus.req0_ready !== (k < 8)) begin
          n_err++;
          $display("FAIL fpp_ready k=%0d: got %b want %b", k, bus.req0_ready, (k < 8));
        end
      end
      if (k == 6) begin
        n_chk++;
        if (bus.rsp0_valid !== 1'b1) begin
          n_err++;
          $display("FAIL fpp_head: got %b want 1", bus.rsp0_valid);
        end
      end
      next_cycle();
    end
    drain(14);
  endtask

  task automatic test_mid_reset();
    int acc;
    acc = 0;
    bus.req1_valid = 1'b1; bus.req1_a = 8'h38; bus.req1_b = 8'h38;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      n_chk++;
      if (bus.req1_ready !== 1'b1) begin
        n_err++;
        $display("FAIL midrst_accept k=%0d: got %b want 1", k, bus.req1_ready);
      end
      next_cycle();
    end
    bus.req1_valid = 1'b0;
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      n_chk++;
      if (bus.rsp1_valid !== 1'b0) begin
        n_err++;
        $display("FAIL midrst_no_rsp k=%0d: got %b want 0", k, bus.rsp1_valid);
      end
      next_cycle();
    end
    bus.rsp1_ready = 1'b0;
    bus.req1_valid = 1'b1;
    for (int k = 0; k < 10; k++) begin
      bus.req1_a = 8'($urandom); bus.req1_b = 8'($urandom);
      @(negedge clk);
      if (bus.req1_ready === 1'b1) acc++;
      next_cycle();
    end
    n_chk++;
    if (acc != FIFO_DEPTH) begin
      n_err++;
      $display("FAIL midrst_accepts: got %0d want %0d", acc, FIFO_DEPTH);
    end
    drain(14);
  endtask

  task automatic test_random();
    for (int k = 0; k < 120; k++) begin
      bus.req0_valid = 1'($urandom);
      bus.req1_valid = 1'($urandom);
      bus.req0_a = 8'($urandom); bus.req0_b = 8'($urandom);
      bus.req1_a = 8'($urandom); bus.req1_b = 8'($urandom);
      bus.rsp0_ready = ($urandom_range(0, 3) != 0);
      bus.rsp1_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      n_chk++;
      if ((bus.req0_ready & bus.req1_ready) !== 1'b0) begin
        n_err++;
        $display("FAIL random_single_grant k=%0d: got %b%b want at most one",
                 k, bus.req0_ready, bus.req1_ready);
      end
      next_cycle();
    end
    drain(16);
  endtask

  initial begin
    n_err = 0;
    n_chk = 0;
    rst   = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_a = 8'h00; bus.req0_b = 8'h00;
    bus.req1_valid = 1'b0; bus.req1_a = 8'h00; bus.req1_b = 8'h00;
    bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
    test_reset();
    drain(10);
    test_single();
    drain(6);
    test_contention();
    drain(6);
    test_backpressure();
    test_full_push_pop();
    test_mid_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
